// File: rtl/rv32i_imm_stage.sv
// rv32i_imm_stage: registered RV32I immediate decode with a small output FIFO.
// Each accepted instruction is classified by opcode and its immediate is
// sign-extended to XLEN. The result is stored with the instruction in a
// DEPTH-entry buffer. The outputs always show the head entry.
module rv32i_imm_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [2:0]      count_o
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

  // The storage is always sized for the largest legal DEPTH (4). This lets
  // the 2-bit pointers index it directly. Only the first DEPTH slots are
  // ever written, because the pointers wrap by compare.
  logic [31:0]     instr_q [4];
  logic [XLEN-1:0] imm_q   [4];
  logic [2:0]      fmt_q   [4];
  logic            ill_q   [4];

  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q;

  logic signed [31:0] imm32_d;
  logic [XLEN-1:0]    imm_d;
  logic [2:0]         fmt_d;
  logic               ill_d;
  logic               push, pop;

  // Opcode classification and immediate bit scatter for the incoming word.
  always_comb begin
    fmt_d   = FMT_ILL;
    ill_d   = 1'b1;
    imm32_d = '0;
    unique case (instr_i[6:0])
      7'b0110111, 7'b0010111: begin
        fmt_d   = FMT_U;
        ill_d   = 1'b0;
        imm32_d = {instr_i[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_d   = FMT_J;
        ill_d   = 1'b0;
        imm32_d = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin
        fmt_d   = FMT_I;
        ill_d   = 1'b0;
        imm32_d = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      7'b0100011: begin
        fmt_d   = FMT_S;
        ill_d   = 1'b0;
        imm32_d = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      7'b1100011: begin
        fmt_d   = FMT_B;
        ill_d   = 1'b0;
        imm32_d = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
      end
      7'b0110011: begin
        fmt_d   = FMT_R;
        ill_d   = 1'b0;
      end
      default: ;
    endcase
    // The signed cast sign-extends the value to XLEN. It covers the
    // XLEN=64 U-type upper half.
    imm_d = XLEN'(imm32_d);
  end

  // Ready only looks at occupancy, so a pop cannot open a slot for a push
  // in the same cycle when the buffer is full.
  always_comb begin
    in_ready_o  = (count_q < DEPTH_C) && rst_ni;
    out_valid_o = (count_q != 3'd0);
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
  end

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == LAST_C) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffer state. Priority is reset, then flush, then push/pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        instr_q[i] <= '0;
        imm_q[i]   <= '0;
        fmt_q[i]   <= '0;
        ill_q[i]   <= 1'b0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= instr_i;
        imm_q[wr_ptr_q]   <= imm_d;
        fmt_q[wr_ptr_q]   <= fmt_d;
        ill_q[wr_ptr_q]   <= ill_d;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The head entry drives the outputs directly.
  always_comb begin
    instr_o   = instr_q[rd_ptr_q];
    imm_o     = imm_q[rd_ptr_q];
    fmt_o     = fmt_q[rd_ptr_q];
    illegal_o = ill_q[rd_ptr_q];
    count_o   = count_q;
  end

endmodule

// File: tb/tb_rv32i_imm_stage.sv
// Bench for rv32i_imm_stage. It runs XLEN=32 and XLEN=64 instances side by
// side on shared stimulus. Both are checked every cycle against a queue
// model built from the RV32I immediate rules.
module tb_rv32i_imm_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] instr32, instr64, imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64, cnt32, cnt64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_imm_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy32), .instr_i(instr), .out_valid_o(vld32),
    .out_ready_i(out_ready), .instr_o(instr32), .imm_o(imm32),
    .fmt_o(fmt32), .illegal_o(ill32), .count_o(cnt32));

  rv32i_imm_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy64), .instr_i(instr), .out_valid_o(vld64),
    .out_ready_i(out_ready), .instr_o(instr64), .imm_o(imm64),
    .fmt_o(fmt64), .illegal_o(ill64), .count_o(cnt64));

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  bit          init    = 0;
  bit          zero_ok = 0;

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h67, 7'h03, 7'h13, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h33:                      return 3'd0;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    longint s, sgn, hi;
    s   = longint'($signed(ins));
    sgn = s >>> 31;
    case (ref_fmt(ins))
      3'd1: begin hi = s >>> 20; return hi; end
      3'd2: begin hi = s >>> 25; return hi * 32 + longint'(ins[11:7]); end
      3'd3: return sgn * 4096 + longint'(ins[7]) * 2048
                   + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd4: begin hi = s >>> 12; return hi * 4096; end
      3'd5: return sgn * 1048576 + longint'(ins[19:12]) * 4096
                   + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        exp_rdy;
    logic [31:0] h;
    if (!init) return;
    exp_rdy = rst_n && (q.size() < 2);
    chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
    chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
    chk("out_valid32", 64'(vld32), 64'(q.size() != 0));
    chk("out_valid64", 64'(vld64), 64'(q.size() != 0));
    chk("count32", 64'(cnt32), 64'(q.size()));
    chk("count64", 64'(cnt64), 64'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("instr32", 64'(instr32), 64'(h));
      chk("instr64", 64'(instr64), 64'(h));
      chk("imm32", 64'(imm32), 64'(ref_imm(h) & 64'hFFFF_FFFF));
      chk("imm64", imm64, ref_imm(h));
      chk("fmt32", 64'(fmt32), 64'(ref_fmt(h)));
      chk("fmt64", 64'(fmt64), 64'(ref_fmt(h)));
      chk("illegal32", 64'(ill32), 64'(ref_fmt(h) == 3'd7));
      chk("illegal64", 64'(ill64), 64'(ref_fmt(h) == 3'd7));
    end else if (zero_ok) begin
      chk("zero_instr", 64'(instr32), 64'd0);
      chk("zero_imm32", 64'(imm32), 64'd0);
      chk("zero_imm64", imm64, 64'd0);
      chk("zero_fmt", 64'(fmt32), 64'd0);
      chk("zero_ill", 64'(ill32), 64'd0);
    end
  endtask

  // One clock: check at negedge, then advance the model at posedge.
  // The caller drives new inputs right after this returns.
  task automatic cycle();
    bit do_push, do_pop;
    @(negedge clk);
    check_all();
    do_push = in_valid && rst_n && (q.size() < 2);
    do_pop  = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      init    = 1;
      zero_ok = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(instr);
        zero_ok = 0;
      end
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] seq_i [3] = '{32'hFE112E23, 32'hFE000CE3, 32'h001000EF};
  logic [31:0] seq_m [3] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0800};
  logic [2:0]  seq_f [3] = '{3'd2, 3'd3, 3'd5};
  logic [6:0]  ops   [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                              7'h73, 7'h23, 7'h63, 7'h33};

  initial begin
    logic [31:0] r;
    int k;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; instr = '0;
    cycle(); cycle();
    rst_n = 1;
    cycle();

    // single addi x1,x0,-1
    out_ready = 1; in_valid = 1; instr = 32'hFFF00093;
    cycle();
    in_valid = 0;
    chk("addi_valid", 64'(vld32), 64'd1);
    chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(fmt32), 64'd1);
    cycle();

    // back-to-back S, B, J
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; instr = seq_i[i];
      cycle();
      chk("b2b_valid", 64'(vld32), 64'd1);
      chk("b2b_imm", 64'(imm32), 64'(seq_m[i]));
      chk("b2b_fmt", 64'(fmt32), 64'(seq_f[i]));
    end
    in_valid = 0;
    cycle();

    // backpressure
    out_ready = 0; in_valid = 1;
    instr = 32'h00500113; cycle();
    instr = 32'h00A00193; cycle();
    instr = 32'h00F00213; cycle();
    chk("bp_count", 64'(cnt32), 64'd2);
    chk("bp_ready", 64'(rdy32), 64'd0);
    chk("bp_head", 64'(instr32), 64'h00500113);
    out_ready = 1;
    cycle();
    chk("bp_pop_ready", 64'(rdy32), 64'd1);
    chk("bp_pop_head", 64'(instr32), 64'h00A00193);
    cycle();
    chk("bp_third_head", 64'(instr32), 64'h00F00213);
    in_valid = 0;
    cycle();

    // LUI on both widths
    in_valid = 1; instr = 32'h800002B7;
    cycle();
    in_valid = 0;
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(imm32), 64'h8000_0000);
    chk("lui_fmt", 64'(fmt64), 64'd4);
    cycle();

    // illegal and R-type
    in_valid = 1; instr = 32'h0000007F;
    cycle();
    chk("ill_flag", 64'(ill32), 64'd1);
    chk("ill_fmt", 64'(fmt32), 64'd7);
    chk("ill_imm", 64'(imm32), 64'd0);
    instr = 32'h002081B3;
    cycle();
    in_valid = 0;
    chk("add_fmt", 64'(fmt32), 64'd0);
    chk("add_imm", 64'(imm32), 64'd0);
    chk("add_ill", 64'(ill32), 64'd0);
    cycle();

    // flush with a full buffer and a push pending
    out_ready = 0; in_valid = 1;
    instr = 32'h00100093; cycle();
    instr = 32'h00200093; cycle();
    flush = 1; instr = 32'h00300093;
    cycle();
    flush = 0; in_valid = 0;
    chk("flush_count", 64'(cnt32), 64'd0);
    chk("flush_valid", 64'(vld32), 64'd0);
    cycle();

    // reset with one entry held
    in_valid = 1; instr = 32'hABCDE537;
    cycle();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_ready_low", 64'(rdy32), 64'd0);
    cycle();
    chk("rst_valid", 64'(vld32), 64'd0);
    chk("rst_count", 64'(cnt32), 64'd0);
    chk("rst_instr", 64'(instr32), 64'd0);
    chk("rst_imm", imm64, 64'd0);
    rst_n = 1;
    cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      k = $urandom_range(0, 10);
      instr     = {r[31:7], (k == 10) ? r[6:0] : ops[k]};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1; flush = 0; in_valid = 0; out_ready = 1;
    cycle(); cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_imm_stage.md
Name: rv32i_imm_stage

Overview:
- Registered immediate-decode stage between fetch and execute.
- Classifies each instruction by opcode into R/I/S/B/U/J and emits one selected immediate, sign-extended to XLEN, plus a format code and an illegal flag.
- Generalises the combinational five-output immediate decoder:
  - parametrised data width;
  - valid/ready handshake on both sides;
  - DEPTH-entry output buffer;
  - synchronous flush.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- DEPTH, 2, buffer entries; legal values 1..4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  synchronous buffer clear.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  stage can accept an instruction.
- instr_i  in  32  instruction word.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head entry.
- instr_o  out  32  instruction of head entry.
- imm_o  out  XLEN  selected immediate of head entry.
- fmt_o  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- illegal_o  out  1  opcode not recognised.
- count_o  out  3  current buffer occupancy, 0..DEPTH.

Behaviour:
- Reset is synchronous: rst_ni=0 at a rising edge.
  - Clears occupancy, read pointer and write pointer.
  - Next cycle: out_valid_o=0, count_o=0, instr_o=0, imm_o=0, fmt_o=0, illegal_o=0.
  - in_ready_o=0 while rst_ni=0 (combinational); it is 1 in the first cycle after release.
  - Reset mid-transfer discards all entries; no partial entry survives.
- Opcode decode uses instr_i[6:0]:
  - 0110111 (LUI), 0010111 (AUIPC) -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110011 -> R, imm=0.
  - Any other opcode -> fmt=7, illegal=1, imm=0.
- Immediate construction (standard RV32I bit scatter, all sign-extended from instr[31] to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 are copies of instr[31].
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Decode happens before the buffer write; each entry stores {instr, imm, fmt, illegal}.
- Push occurs when in_valid_i && in_ready_o.
- Pop occurs when out_valid_o && out_ready_i.
- in_ready_o = (count < DEPTH) && rst_ni.
  - It does not depend on out_ready_i; there is no combinational ready path.
  - When full, a simultaneous pop does not enable a push in that cycle.
- out_valid_o = (count != 0). Outputs come from the head entry and are stable while out_valid_o=1 and out_ready_i=0.
- Latency: an instruction pushed in cycle N is visible on the outputs in cycle N+1 if the buffer was empty. Throughput is 1/cycle when out_ready_i is held high.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and order is preserved (FIFO).
- Pointers wrap modulo DEPTH. DEPTH need not be a power of 2; wrap is by compare, not truncation.
- flush_i=1 takes priority over push and pop:
  - next cycle count=0 and out_valid_o=0;
  - any push or pop in the flush cycle is dropped;
  - the output data registers may retain stale values but must be ignored.
- rst_ni takes priority over flush_i.
- Pushing when not ready is ignored: in_valid_i may stay high and the instruction is held upstream.
- Illegal instructions pass through the buffer like any other entry. The stage never stalls on them.

Test Plan:
- XLEN=32, DEPTH=2, out_ready_i=1: push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1.
- Back-to-back pushes of 0xFE112E23, 0xFE000CE3, 0x001000EF with out_ready_i=1:
  - imm_o sequence is 0xFFFFFFFC (S), 0xFFFFFFF8 (B), 0x00000800 (J);
  - fmt_o sequence is 2, 3, 5;
  - one result per cycle.
- Backpressure: out_ready_i=0, push 3 instructions.
  - After 2 accepted: count_o=2, in_ready_o=0, third held.
  - Raise out_ready_i: first result pops; in_ready_o returns to 1 the following cycle; order is preserved.
- XLEN=64: push 0x800002B7 (lui x5,0x80000) -> imm_o=0xFFFFFFFF80000000, fmt_o=4. Repeat with XLEN=32 -> imm_o=0x80000000.
- Illegal opcode and R-type:
  - push 0x0000007F -> illegal_o=1, fmt_o=7, imm_o=0;
  - push 0x002081B3 (add) -> fmt_o=0, imm_o=0, illegal_o=0.
- Flush/reset:
  - count_o=2, assert flush_i with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, pushed instruction dropped.
  - Separately, rst_ni=0 with count_o=1 -> next cycle all outputs 0; in_ready_o=0 during reset.
